// File: rtl/booth_div.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per cycle, followed by a sign-correction step.
module booth_div #(
    parameter int WORD_LEN = 8
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_start,
    input  logic [WORD_LEN-1:0] i_dividend,
    input  logic [WORD_LEN-1:0] i_divisor,
    output logic                o_busy,
    output logic                o_done,
    output logic [WORD_LEN-1:0] o_reg_quotient,
    output logic [WORD_LEN-1:0] o_reg_remainder,
    output logic                o_div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = $clog2(WORD_LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_LEN - 1);

    state_t state, state_next;

    logic [CW-1:0]       count;
    logic [WORD_LEN-1:0] dividend_q;
    logic [WORD_LEN-1:0] dvd_shift;
    logic [WORD_LEN-1:0] quo_mag;
    logic [WORD_LEN-1:0] rem_mag;
    logic [WORD_LEN:0]   dsr_mag;
    logic                neg_dividend;
    logic                neg_divisor;

    logic [WORD_LEN-1:0] dvd_mag_in;
    logic [WORD_LEN:0]   dsr_mag_in;
    logic [WORD_LEN:0]   shifted;
    logic                fits;

    // The most negative dividend's magnitude is exactly 2^(WORD_LEN-1), which still fits unsigned.
    always_comb begin
        dvd_mag_in = i_dividend[WORD_LEN-1] ? (~i_dividend + 1'b1) : i_dividend;
        dsr_mag_in = {1'b0, (i_divisor[WORD_LEN-1] ? (~i_divisor + 1'b1) : i_divisor)};
        shifted    = {rem_mag, dvd_shift[WORD_LEN-1]};
        fits       = (shifted >= dsr_mag);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = CALC;
            CALC:    if (count == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count           <= '0;
            dividend_q      <= '0;
            dvd_shift       <= '0;
            quo_mag         <= '0;
            rem_mag         <= '0;
            dsr_mag         <= '0;
            neg_dividend    <= 1'b0;
            neg_divisor     <= 1'b0;
            o_done          <= 1'b0;
            o_reg_quotient  <= '0;
            o_reg_remainder <= '0;
            o_div_by_zero   <= 1'b0;
        end else begin
            o_done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (i_start) begin
                        dividend_q   <= i_dividend;
                        neg_dividend <= i_dividend[WORD_LEN-1];
                        neg_divisor  <= i_divisor[WORD_LEN-1];
                        dvd_shift    <= dvd_mag_in;
                        dsr_mag      <= dsr_mag_in;
                        rem_mag      <= '0;
                        quo_mag      <= '0;
                        count        <= '0;
                    end
                end
                CALC: begin
                    rem_mag   <= fits ? WORD_LEN'(shifted - dsr_mag) : shifted[WORD_LEN-1:0];
                    quo_mag   <= {quo_mag[WORD_LEN-2:0], fits};
                    dvd_shift <= {dvd_shift[WORD_LEN-2:0], 1'b0};
                    count     <= count + 1'b1;
                end
                FIX: begin
                    // A zero divisor makes every trial succeed; report -1 and the dividend instead.
                    if (dsr_mag == '0) begin
                        o_reg_quotient  <= '1;
                        o_reg_remainder <= dividend_q;
                        o_div_by_zero   <= 1'b1;
                    end else begin
                        o_reg_quotient  <= (neg_dividend ^ neg_divisor) ? (~quo_mag + 1'b1) : quo_mag;
                        o_reg_remainder <= neg_dividend ? (~rem_mag + 1'b1) : rem_mag;
                        o_div_by_zero   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_div.sv
// Directed-vector and random bench for booth_div with WORD_LEN=8.
module tb_booth_div;

    logic       i_clk = 1'b0;
    logic       i_rstn;
    logic       i_start;
    logic [7:0] i_dividend;
    logic [7:0] i_divisor;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_reg_quotient;
    logic [7:0] o_reg_remainder;
    logic       o_div_by_zero;

    int errors = 0;
    int checks = 0;

    booth_div #(.WORD_LEN(8)) dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .i_start         (i_start),
        .i_dividend      (i_dividend),
        .i_divisor       (i_divisor),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_reg_quotient  (o_reg_quotient),
        .o_reg_remainder (o_reg_remainder),
        .o_div_by_zero   (o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
    } vec_t;

    vec_t vecs[12];

    task automatic check_output(input string name, input logic signed [31:0] actual,
                                input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Issues one division from just after a clock edge and follows it to o_done.
    task automatic apply_stimulus(input int a, input int b, input int disturb_at,
                                  output int lat, output int busy_cnt, output logic done_seen);
        i_dividend = 8'(a);
        i_divisor  = 8'(b);
        i_start    = 1'b1;
        @(posedge i_clk); #1;
        i_start   = 1'b0;
        busy_cnt  = o_busy ? 1 : 0;
        lat       = 0;
        done_seen = 1'b0;
        while (lat < 30 && !done_seen) begin
            if (disturb_at != 0 && lat == disturb_at) begin
                i_start    = 1'b1;
                i_dividend = 8'd20;
                i_divisor  = 8'd3;
            end
            @(posedge i_clk); #1;
            i_start = 1'b0;
            lat++;
            if (o_done) done_seen = 1'b1;
            else if (o_busy) busy_cnt++;
        end
    endtask

    initial begin
        int lat, busy_cnt, done_cnt, qa, ra;
        logic done_seen;
        logic [7:0] ua, ub;
        string tag;

        vecs[0]  = '{100, 7, 14, 2, 0};
        vecs[1]  = '{-100, 7, -14, -2, 0};
        vecs[2]  = '{100, -7, -14, 2, 0};
        vecs[3]  = '{-100, -7, 14, -2, 0};
        vecs[4]  = '{5, 9, 0, 5, 0};
        vecs[5]  = '{-128, -1, -128, 0, 0};
        vecs[6]  = '{-128, 1, -128, 0, 0};
        vecs[7]  = '{127, -128, 0, 127, 0};
        vecs[8]  = '{-128, -128, 1, 0, 0};
        vecs[9]  = '{55, 0, -1, 55, 1};
        vecs[10] = '{20, 3, 6, 2, 0};
        vecs[11] = '{-55, 0, -1, -55, 1};

        i_rstn     = 1'b0;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check_output("reset busy", o_busy, 0);
        check_output("reset done", o_done, 0);
        check_output("reset quotient", o_reg_quotient, 0);
        check_output("reset remainder", o_reg_remainder, 0);
        check_output("reset div_by_zero", o_div_by_zero, 0);
        i_rstn = 1'b1;
        @(posedge i_clk); #1;

        // Each vector is issued in the previous one's done cycle, so these are back-to-back.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, 0, lat, busy_cnt, done_seen);
            tag = $sformatf("%0d/%0d", vecs[i].a, vecs[i].b);
            check_output({"done seen ", tag}, done_seen, 1);
            check_output({"latency ", tag}, lat, 9);
            check_output({"busy cycles ", tag}, busy_cnt, 9);
            check_output({"busy at done ", tag}, o_busy, 0);
            check_output({"quotient ", tag}, $signed(o_reg_quotient), vecs[i].q);
            check_output({"remainder ", tag}, $signed(o_reg_remainder), vecs[i].r);
            check_output({"div_by_zero ", tag}, o_div_by_zero, vecs[i].z);
        end

        @(posedge i_clk); #1;
        check_output("done pulse width", o_done, 0);
        check_output("quotient hold", $signed(o_reg_quotient), -1);
        check_output("div_by_zero hold", o_div_by_zero, 1);

        apply_stimulus(100, 7, 3, lat, busy_cnt, done_seen);
        check_output("ignored start latency", lat, 9);
        check_output("ignored start quotient", $signed(o_reg_quotient), 14);
        check_output("ignored start remainder", $signed(o_reg_remainder), 2);
        check_output("ignored start div_by_zero", o_div_by_zero, 0);

        i_dividend = 8'd100;
        i_divisor  = 8'd7;
        i_start    = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_rstn = 1'b0;
        #1;
        check_output("abort busy", o_busy, 0);
        check_output("abort done", o_done, 0);
        check_output("abort quotient", o_reg_quotient, 0);
        check_output("abort remainder", o_reg_remainder, 0);
        check_output("abort div_by_zero", o_div_by_zero, 0);
        #2;
        i_rstn   = 1'b1;
        done_cnt = 0;
        repeat (15) begin
            @(posedge i_clk); #1;
            if (o_done) done_cnt++;
        end
        check_output("no done after abort", done_cnt, 0);

        for (int n = 0; n < 1000; n++) begin
            ua = 8'($urandom_range(0, 255));
            ub = 8'($urandom_range(1, 255));
            apply_stimulus(int'($signed(ua)), int'($signed(ub)), 0, lat, busy_cnt, done_seen);
            qa = int'($signed(ua)) / int'($signed(ub));
            ra = int'($signed(ua)) % int'($signed(ub));
            tag = $sformatf("%0d/%0d", $signed(ua), $signed(ub));
            check_output({"rand done ", tag}, done_seen, 1);
            check_output({"rand quotient ", tag}, $signed(o_reg_quotient), $signed(8'(qa)));
            check_output({"rand remainder ", tag}, $signed(o_reg_remainder), $signed(8'(ra)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
